regfile_scoreboard: RTL and testbench



---
 rtl/regfile_scoreboard_pkg.sv | 21 ++
 rtl/regfile_scoreboard_rf_scoreboard.sv | 54 +++++
 rtl/regfile_scoreboard.sv | 101 ++++++++++
 tb/tb_regfile_scoreboard.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// rtl/regfile_scoreboard_pkg.sv - shared defaults, derived depth, mode constants and read-source enum
package regfile_scoreboard_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 3;
  localparam int DEPTH_DEF    = 1 << ADDR_W_DEF;

  localparam bit BYPASS_OFF   = 1'b0;
  localparam bit BYPASS_ON    = 1'b1;
  localparam bit ZERO_REG_OFF = 1'b0;
  localparam bit ZERO_REG_ON  = 1'b1;

  // Where a read port takes its data from in the current cycle
  typedef enum logic [1:0] {
    SRC_STORED = 2'd0,
    SRC_WD0    = 2'd1,
    SRC_WD1    = 2'd2,
    SRC_ZERO   = 2'd3
  } rd_src_e;

endpackage

// File: rtl/regfile_scoreboard_rf_scoreboard.sv
// rtl/regfile_scoreboard_rf_scoreboard.sv - per-register busy bits with issue/write-back priority and registered busy count
module rf_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = ZERO_REG_OFF
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  output logic [(1<<ADDR_W)-1:0]   busy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_nxt;
  logic [ADDR_W:0]  busy_pop;

  // Issue beats write-back: the write retires the older producer of the register
  always_comb begin
    busy_nxt = busy;
    for (int r = 0; r < DEPTH; r++) begin
      if (ZERO_REG && r == 0)
        busy_nxt[r] = 1'b0;
      else if (iss_valid && iss_addr == ADDR_W'(r))
        busy_nxt[r] = 1'b1;
      else if ((we0 && wa0 == ADDR_W'(r)) || (we1 && wa1 == ADDR_W'(r)))
        busy_nxt[r] = 1'b0;
    end
  end

  always_comb begin
    busy_pop = '0;
    for (int r = 0; r < DEPTH; r++)
      busy_pop = busy_pop + {{ADDR_W{1'b0}}, busy[r]};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= busy_pop;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 2R/2W register file with optional bypass, optional zero register and busy scoreboard
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit BYPASS   = BYPASS_ON,
  parameter bit ZERO_REG = ZERO_REG_OFF
) (
  input  logic                                 clk,
  input  logic                                 n_rst,
  input  logic [ADDR_W-1:0]                    ra1,
  input  logic [ADDR_W-1:0]                    ra2,
  output logic [DATA_W-1:0]                    rd1,
  output logic [DATA_W-1:0]                    rd2,
  output logic                                 rbusy1,
  output logic                                 rbusy2,
  input  logic [ADDR_W-1:0]                    wa0,
  input  logic [ADDR_W-1:0]                    wa1,
  input  logic [DATA_W-1:0]                    wd0,
  input  logic [DATA_W-1:0]                    wd1,
  input  logic                                 we0,
  input  logic                                 we1,
  input  logic                                 iss_valid,
  input  logic [ADDR_W-1:0]                    iss_addr,
  output logic [ADDR_W:0]                      busy_cnt,
  output logic [(1<<ADDR_W)*DATA_W-1:0]        rf_flat
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] rf [DEPTH];
  logic [DEPTH-1:0]  busy;
  rd_src_e           src1, src2;

  rf_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
    .clk       (clk),
    .n_rst     (n_rst),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .we0       (we0),
    .wa0       (wa0),
    .we1       (we1),
    .wa1       (wa1),
    .busy      (busy),
    .busy_cnt  (busy_cnt)
  );

  // Port 1 wins a same-address collision
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++)
        rf[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!(ZERO_REG && i == 0)) begin
          if (we1 && wa1 == ADDR_W'(i))
            rf[i] <= wd1;
          else if (we0 && wa0 == ADDR_W'(i))
            rf[i] <= wd0;
        end
      end
    end
  end

  // The zero register overrides bypass
  function automatic rd_src_e rd_src(input logic [ADDR_W-1:0] ra,
                                     input logic w0, input logic [ADDR_W-1:0] a0,
                                     input logic w1, input logic [ADDR_W-1:0] a1);
    if (ZERO_REG && ra == '0)   return SRC_ZERO;
    if (BYPASS && w1 && a1 == ra) return SRC_WD1;
    if (BYPASS && w0 && a0 == ra) return SRC_WD0;
    return SRC_STORED;
  endfunction

  always_comb begin
    src1 = rd_src(ra1, we0, wa0, we1, wa1);
    src2 = rd_src(ra2, we0, wa0, we1, wa1);
    rd1  = rf[ra1];
    rd2  = rf[ra2];
    case (src1)
      SRC_WD1:  rd1 = wd1;
      SRC_WD0:  rd1 = wd0;
      SRC_ZERO: rd1 = '0;
      default:  rd1 = rf[ra1];
    endcase
    case (src2)
      SRC_WD1:  rd2 = wd1;
      SRC_WD0:  rd2 = wd0;
      SRC_ZERO: rd2 = '0;
      default:  rd2 = rf[ra2];
    endcase
    rbusy1 = (src1 == SRC_STORED) ? busy[ra1] : 1'b0;
    rbusy2 = (src2 == SRC_STORED) ? busy[ra2] : 1'b0;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign rf_flat[g*DATA_W +: DATA_W] = rf[g];
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - bench for regfile_scoreboard in bypass and zero-register configurations
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [2:0]  ra1, ra2, wa0, wa1, iss_addr;
  logic [31:0] wd0, wd1;
  logic        we0, we1, iss_valid;

  logic [31:0]  rd1_o [2];
  logic [31:0]  rd2_o [2];
  logic         rb1_o [2];
  logic         rb2_o [2];
  logic [3:0]   cnt_o [2];
  logic [255:0] flat_o [2];

  int n_cmp = 0;
  int n_bad = 0;

  // d=0: bypass on, no zero reg; d=1: bypass off, zero reg on
  logic [31:0] m_mem  [2][8];
  logic        m_busy [2][8];
  int          m_cnt  [2];

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(3), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut_a (
    .clk(clk), .n_rst(n_rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_o[0]), .rd2(rd2_o[0]),
    .rbusy1(rb1_o[0]), .rbusy2(rb2_o[0]), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .we0(we0), .we1(we1), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .busy_cnt(cnt_o[0]), .rf_flat(flat_o[0]));

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(3), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_b (
    .clk(clk), .n_rst(n_rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_o[1]), .rd2(rd2_o[1]),
    .rbusy1(rb1_o[1]), .rbusy2(rb2_o[1]), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .we0(we0), .we1(we1), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .busy_cnt(cnt_o[1]), .rf_flat(flat_o[1]));

  function automatic bit byp(int d);   return d == 0; endfunction
  function automatic bit zr(int d);    return d == 1; endfunction

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: writes applied in port order so port 1 lands last; issue applied after clears
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int d = 0; d < 2; d++) begin
        m_cnt[d] <= 0;
        for (int r = 0; r < 8; r++) begin
          m_mem[d][r]  <= '0;
          m_busy[d][r] <= 1'b0;
        end
      end
    end else begin
      for (int d = 0; d < 2; d++) begin : upd
        int c;
        c = 0;
        for (int r = 0; r < 8; r++) c += int'(m_busy[d][r]);
        m_cnt[d] <= c;
        if (we0 && !(zr(d) && wa0 == 0)) m_mem[d][wa0] <= wd0;
        if (we1 && !(zr(d) && wa1 == 0)) m_mem[d][wa1] <= wd1;
        if (we0) m_busy[d][wa0] <= 1'b0;
        if (we1) m_busy[d][wa1] <= 1'b0;
        if (iss_valid && !(zr(d) && iss_addr == 0)) m_busy[d][iss_addr] <= 1'b1;
      end
    end
  end

  function automatic logic [31:0] exp_rd(int d, logic [2:0] ra);
    if (zr(d) && ra == 0) return '0;
    if (byp(d) && we1 && wa1 == ra) return wd1;
    if (byp(d) && we0 && wa0 == ra) return wd0;
    return m_mem[d][ra];
  endfunction

  function automatic logic exp_rb(int d, logic [2:0] ra);
    if (zr(d) && ra == 0) return 1'b0;
    if (byp(d) && ((we1 && wa1 == ra) || (we0 && wa0 == ra))) return 1'b0;
    return m_busy[d][ra];
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [255:0] f;
      f = '0;
      for (int r = 0; r < 8; r++) f[r*32 +: 32] = m_mem[d][r];
      check($sformatf("d%0d rd1", d),      256'(rd1_o[d]),  256'(exp_rd(d, ra1)));
      check($sformatf("d%0d rd2", d),      256'(rd2_o[d]),  256'(exp_rd(d, ra2)));
      check($sformatf("d%0d rbusy1", d),   256'(rb1_o[d]),  256'(exp_rb(d, ra1)));
      check($sformatf("d%0d rbusy2", d),   256'(rb2_o[d]),  256'(exp_rb(d, ra2)));
      check($sformatf("d%0d busy_cnt", d), 256'(cnt_o[d]),  256'(m_cnt[d]));
      check($sformatf("d%0d rf_flat", d),  flat_o[d],       f);
    end
  end

  task automatic idle();
    we0 = 0; we1 = 0; iss_valid = 0;
    wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; iss_addr = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    n_rst = 1'b0;
    idle(); ra1 = 0; ra2 = 0;
    cyc(); cyc();
    n_rst = 1'b1;
    #2;
    check("reset rf_flat", flat_o[0], '0);
    check("reset busy_cnt", 256'(cnt_o[0]), 256'(0));
    check("reset rbusy1", 256'(rb1_o[0]), 256'(0));

    // Single write with same-cycle read
    cyc();
    we0 = 1; wa0 = 3; wd0 = 32'hDEADBEEF; ra1 = 3;
    #2;
    check("bypass rd1 same cycle", 256'(rd1_o[0]), 256'(32'hDEADBEEF));
    check("nobypass rd1 same cycle", 256'(rd1_o[1]), 256'(0));
    cyc(); idle(); #2;
    check("nobypass rd1 after edge", 256'(rd1_o[1]), 256'(32'hDEADBEEF));

    // Dual write collision
    cyc();
    we0 = 1; wa0 = 5; wd0 = 32'h11; we1 = 1; wa1 = 5; wd1 = 32'h22; ra2 = 5;
    #2;
    check("collision bypass rd2", 256'(rd2_o[0]), 256'(32'h22));
    cyc(); idle(); #2;
    check("collision stored a", 256'(rd2_o[0]), 256'(32'h22));
    check("collision stored b", 256'(flat_o[1][5*32 +: 32]), 256'(32'h22));

    // Issue, lagged count, write-back clear
    iss_valid = 1; iss_addr = 2; ra1 = 2;
    cyc(); idle(); #2;
    check("issue rbusy1", 256'(rb1_o[0]), 256'(1));
    check("issue cnt lag", 256'(cnt_o[0]), 256'(0));
    cyc(); #2;
    check("issue cnt", 256'(cnt_o[0]), 256'(1));
    we1 = 1; wa1 = 2; wd1 = 32'h7; #2;
    check("wb bypass rbusy1", 256'(rb1_o[0]), 256'(0));
    check("wb nobypass rbusy1", 256'(rb1_o[1]), 256'(1));
    cyc(); idle(); #2;
    check("wb cleared", 256'(rb1_o[1]), 256'(0));
    check("wb cnt lag", 256'(cnt_o[0]), 256'(1));
    cyc(); #2;
    check("wb cnt", 256'(cnt_o[0]), 256'(0));
    iss_valid = 1; iss_addr = 2; we0 = 1; wa0 = 2; wd0 = 32'h9;
    cyc(); idle(); #2;
    check("issue beats wb", 256'(rb1_o[0]), 256'(1));

    // Zero register
    we0 = 1; wa0 = 0; wd0 = 32'hFFFF_FFFF; iss_valid = 1; iss_addr = 0; ra1 = 0;
    #2;
    check("zero rd1 same cycle", 256'(rd1_o[1]), 256'(0));
    cyc(); idle(); #2;
    check("zero rd1", 256'(rd1_o[1]), 256'(0));
    check("zero rbusy1", 256'(rb1_o[1]), 256'(0));
    check("nonzero reg0 stored", 256'(rd1_o[0]), 256'(32'hFFFF_FFFF));
    cyc(); cyc(); #2;
    check("zero cnt b", 256'(cnt_o[1]), 256'(1));
    check("zero cnt a", 256'(cnt_o[0]), 256'(2));

    // Fill the scoreboard, then asynchronous reset between edges
    for (int i = 0; i < 8; i++) begin
      iss_valid = 1; iss_addr = 3'(i);
      cyc();
    end
    idle(); cyc(); #2;
    check("full cnt a", 256'(cnt_o[0]), 256'(8));
    check("full cnt b", 256'(cnt_o[1]), 256'(7));
    ra1 = 4; ra2 = 7;
    #1 n_rst = 1'b0;
    #1;
    check("async cnt", 256'(cnt_o[0]), 256'(0));
    check("async rbusy1", 256'(rb1_o[0]), 256'(0));
    check("async rbusy2", 256'(rb2_o[1]), 256'(0));
    check("async flat", flat_o[0], '0);
    cyc();
    n_rst = 1'b1;
    cyc(); cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
